// File: rtl/msfsm_hs_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : msfsm_hs_adapter_if
// Purpose  : Handshake/event bundle between the MSFSM controller and adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface msfsm_hs_adapter_if #(
  parameter int CNT_W = 16
);
  logic             Ri;
  logic             Ai;
  logic             Ro_PLUS;
  logic             Ro_MINUS;
  logic             Ao_PLUS;
  logic             Ao_MINUS;
  logic             err_clr;
  logic             Ri_PLUS;
  logic             Ri_MINUS;
  logic             Ai_PLUS;
  logic             Ai_MINUS;
  logic             Ro;
  logic             Ao;
  logic [2:0]       err;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output Ri, Ai, Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS, err_clr,
    input  Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, Ro, Ao, err, xfer_cnt
  );

  modport slave (
    input  Ri, Ai, Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS, err_clr,
    output Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, Ro, Ao, err, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/msfsm_hs_adapter.sv
`default_nettype none
// ============================================================================
// Module   : msfsm_hs_adapter
// Purpose  : 4-phase level handshake <-> MSFSM event adapter with protocol
//            checking; MSFSM_HS_SYNC_IN_EN adds a 2-flop input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module msfsm_hs_adapter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  msfsm_hs_adapter_if.slave hs
);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0, L_REQ = 2'd1, L_ACK = 2'd2, L_REL = 2'd3
  } l_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0, R_REQ = 2'd1, R_ACK = 2'd2, R_REL = 2'd3
  } r_state_t;

  logic ri_src;
  logic ai_src;

`ifdef MSFSM_HS_SYNC_IN_EN
  logic [1:0] ri_sync_q;
  logic [1:0] ai_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ri_sync_q <= 2'b00;
      ai_sync_q <= 2'b00;
    end else begin
      ri_sync_q <= {ri_sync_q[0], hs.Ri};
      ai_sync_q <= {ai_sync_q[0], hs.Ai};
    end
  end

  assign ri_src = ri_sync_q[1];
  assign ai_src = ai_sync_q[1];
`else
  assign ri_src = hs.Ri;
  assign ai_src = hs.Ai;
`endif

  logic ri_s_q, ri_p_q, ai_s_q, ai_p_q;
  logic ri_plus_q, ri_minus_q, ai_plus_q, ai_minus_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ri_s_q     <= 1'b0;
      ri_p_q     <= 1'b0;
      ai_s_q     <= 1'b0;
      ai_p_q     <= 1'b0;
      ri_plus_q  <= 1'b0;
      ri_minus_q <= 1'b0;
      ai_plus_q  <= 1'b0;
      ai_minus_q <= 1'b0;
    end else begin
      ri_s_q     <= ri_src;
      ri_p_q     <= ri_s_q;
      ai_s_q     <= ai_src;
      ai_p_q     <= ai_s_q;
      ri_plus_q  <= ri_s_q & ~ri_p_q;
      ri_minus_q <= ~ri_s_q & ri_p_q;
      ai_plus_q  <= ai_s_q & ~ai_p_q;
      ai_minus_q <= ~ai_s_q & ai_p_q;
    end
  end

  l_state_t         l_state_q;
  r_state_t         r_state_q;
  logic             ro_q;
  logic             ao_q;
  logic [2:0]       err_q;
  logic [2:0]       err_d;
  logic [CNT_W-1:0] xfer_cnt_q;
  logic [3:0]       l_ev;
  logic [3:0]       r_ev;
  logic             l_legal, r_legal, l_acc, r_acc, cmd_conflict;

  // A cycle with more than one event on a channel is rejected outright,
  // even when one of those events would have been legal on its own.
  always_comb begin
    l_ev = {hs.Ao_MINUS, ri_minus_q, hs.Ao_PLUS, ri_plus_q};
    r_ev = {ai_minus_q, hs.Ro_MINUS, ai_plus_q, hs.Ro_PLUS};
    l_legal = 1'b0;
    r_legal = 1'b0;
    unique case (l_state_q)
      L_IDLE: l_legal = ri_plus_q;
      L_REQ:  l_legal = hs.Ao_PLUS;
      L_ACK:  l_legal = ri_minus_q;
      L_REL:  l_legal = hs.Ao_MINUS;
    endcase
    unique case (r_state_q)
      R_IDLE: r_legal = hs.Ro_PLUS;
      R_REQ:  r_legal = ai_plus_q;
      R_ACK:  r_legal = hs.Ro_MINUS;
      R_REL:  r_legal = ai_minus_q;
    endcase
    l_acc        = l_legal && $onehot(l_ev);
    r_acc        = r_legal && $onehot(r_ev);
    cmd_conflict = (hs.Ao_PLUS & hs.Ao_MINUS) | (hs.Ro_PLUS & hs.Ro_MINUS);
    err_d        = (err_q & {3{~hs.err_clr}})
                 | {cmd_conflict, (|r_ev) & ~r_acc, (|l_ev) & ~l_acc};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_state_q  <= L_IDLE;
      r_state_q  <= R_IDLE;
      ro_q       <= 1'b0;
      ao_q       <= 1'b0;
      err_q      <= 3'b000;
      xfer_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (l_acc) begin
        unique case (l_state_q)
          L_IDLE: l_state_q <= L_REQ;
          L_REQ: begin
            l_state_q <= L_ACK;
            ao_q      <= 1'b1;
          end
          L_ACK: l_state_q <= L_REL;
          L_REL: begin
            l_state_q <= L_IDLE;
            ao_q      <= 1'b0;
          end
        endcase
      end
      if (r_acc) begin
        unique case (r_state_q)
          R_IDLE: begin
            r_state_q <= R_REQ;
            ro_q      <= 1'b1;
          end
          R_REQ: r_state_q <= R_ACK;
          R_ACK: begin
            r_state_q <= R_REL;
            ro_q      <= 1'b0;
          end
          R_REL: begin
            r_state_q  <= R_IDLE;
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
          end
        endcase
      end
    end
  end

  assign hs.Ri_PLUS  = ri_plus_q;
  assign hs.Ri_MINUS = ri_minus_q;
  assign hs.Ai_PLUS  = ai_plus_q;
  assign hs.Ai_MINUS = ai_minus_q;
  assign hs.Ro       = ro_q;
  assign hs.Ao       = ao_q;
  assign hs.err      = err_q;
  assign hs.xfer_cnt = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_msfsm_hs_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_msfsm_hs_adapter
// Purpose  : Self-checking bench: directed protocol scenarios plus random
//            traffic compared every cycle against a phase-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msfsm_hs_adapter;

  localparam int CNT_W = 4;
`ifdef MSFSM_HS_SYNC_IN_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic clk;
  logic reset;
  logic chk_on;
  int   n_chk;
  int   n_fail;

  msfsm_hs_adapter_if #(.CNT_W(CNT_W)) hs ();

  msfsm_hs_adapter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  // Reference: each channel is a phase 0..3 that accepts only event #phase,
  // pulses come from the raw input history delayed by the sampling depth.
  bit ri_h[$];
  bit ai_h[$];
  bit m_rip, m_rim, m_aip, m_aim, m_ro, m_ao;
  bit [2:0] m_err;
  int lp, rp, m_cnt;

  task automatic m_reset();
    ri_h = {};
    ai_h = {};
    repeat (D + 2) begin
      ri_h.push_back(1'b0);
      ai_h.push_back(1'b0);
    end
    {m_rip, m_rim, m_aip, m_aim, m_ro, m_ao} = 6'b0;
    m_err = 3'b000;
    lp = 0;
    rp = 0;
    m_cnt = 0;
  endtask

  task automatic m_step();
    bit [3:0] le;
    bit [3:0] re;
    bit [2:0] ne;
    le = {hs.Ao_MINUS, m_rim, hs.Ao_PLUS, m_rip};
    re = {m_aim, hs.Ro_MINUS, m_aip, hs.Ro_PLUS};
    ne = 3'b000;
    if ($countones(le) == 1 && le[lp]) begin
      if (lp == 1) m_ao = 1'b1;
      if (lp == 3) m_ao = 1'b0;
      lp = (lp + 1) % 4;
    end else if (le != 4'b0) ne[0] = 1'b1;
    if ($countones(re) == 1 && re[rp]) begin
      if (rp == 0) m_ro = 1'b1;
      if (rp == 2) m_ro = 1'b0;
      if (rp == 3) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      rp = (rp + 1) % 4;
    end else if (re != 4'b0) ne[1] = 1'b1;
    ne[2] = (hs.Ao_PLUS & hs.Ao_MINUS) | (hs.Ro_PLUS & hs.Ro_MINUS);
    m_err = (hs.err_clr ? 3'b000 : m_err) | ne;
    ri_h.push_front(hs.Ri);
    ai_h.push_front(hs.Ai);
    void'(ri_h.pop_back());
    void'(ai_h.pop_back());
    m_rip = ri_h[D] & ~ri_h[D+1];
    m_rim = ~ri_h[D] & ri_h[D+1];
    m_aip = ai_h[D] & ~ai_h[D+1];
    m_aim = ~ai_h[D] & ai_h[D+1];
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_Ri_PLUS",  hs.Ri_PLUS,  m_rip);
      chk("model_Ri_MINUS", hs.Ri_MINUS, m_rim);
      chk("model_Ai_PLUS",  hs.Ai_PLUS,  m_aip);
      chk("model_Ai_MINUS", hs.Ai_MINUS, m_aim);
      chk("model_Ro",       hs.Ro,       m_ro);
      chk("model_Ao",       hs.Ao,       m_ao);
      chk("model_err",      hs.err,      m_err);
      chk("model_xfer_cnt", hs.xfer_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clr_cmds();
    hs.Ro_PLUS  = 1'b0;
    hs.Ro_MINUS = 1'b0;
    hs.Ao_PLUS  = 1'b0;
    hs.Ao_MINUS = 1'b0;
    hs.err_clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr_cmds();
    hs.Ri = 1'b0;
    hs.Ai = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic rcycle();
    hs.Ro_PLUS = 1'b1;
    tick();
    hs.Ro_PLUS = 1'b0;
    chk("rcyc_Ro_set", hs.Ro, 1);
    hs.Ai = 1'b1;
    repeat (D + 2) tick();
    hs.Ro_MINUS = 1'b1;
    tick();
    hs.Ro_MINUS = 1'b0;
    chk("rcyc_Ro_clr", hs.Ro, 0);
    hs.Ai = 1'b0;
    repeat (D + 2) tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    chk_on = 1'b0;
    reset  = 1'b0;
    hs.Ri  = 1'b0;
    hs.Ai  = 1'b0;
    clr_cmds();
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_Ro", hs.Ro, 0);
    chk("rst_Ao", hs.Ao, 0);
    chk("rst_err", hs.err, 0);
    chk("rst_cnt", hs.xfer_cnt, 0);
    chk("rst_Ri_PLUS", hs.Ri_PLUS, 0);
    reset = 1'b1;

    // Ri rising edge: pulse appears D+1 edges after the change, for one cycle
    hs.Ri = 1'b1;
    tick();
    chk("ri_plus_early", hs.Ri_PLUS, 0);
    repeat (D) tick();
    chk("ri_plus_high", hs.Ri_PLUS, 1);
    tick();
    chk("ri_plus_gone", hs.Ri_PLUS, 0);
    hs.Ao_PLUS = 1'b1;
    tick();
    hs.Ao_PLUS = 1'b0;
    chk("l_req_Ao", hs.Ao, 1);
    chk("l_req_err", hs.err, 0);
    hs.Ao_PLUS  = 1'b1;
    hs.Ao_MINUS = 1'b1;
    tick();
    clr_cmds();
    chk("conflict_err", hs.err, 3'b101);
    chk("conflict_Ao", hs.Ao, 1);

    // Right channel cycles and counter wrap at CNT_W=4
    do_reset();
    repeat (3) rcycle();
    chk("three_cnt", hs.xfer_cnt, 3);
    chk("three_err", hs.err, 0);
    repeat (12) rcycle();
    chk("fifteen_cnt", hs.xfer_cnt, 15);
    rcycle();
    chk("wrap_cnt", hs.xfer_cnt, 0);

    // Repeated Ro_PLUS while waiting for acknowledge
    do_reset();
    hs.Ro_PLUS = 1'b1;
    tick();
    tick();
    hs.Ro_PLUS = 1'b0;
    chk("dup_err", hs.err, 3'b010);
    chk("dup_Ro", hs.Ro, 1);
    hs.err_clr = 1'b1;
    tick();
    hs.err_clr = 1'b0;
    chk("clr_err", hs.err, 0);
    hs.Ai = 1'b1;
    repeat (D + 2) tick();
    chk("still_req_err", hs.err, 0);
    hs.Ro_MINUS = 1'b1;
    tick();
    hs.Ro_MINUS = 1'b0;
    hs.Ai = 1'b0;
    repeat (D + 2) tick();
    chk("one_cnt", hs.xfer_cnt, 1);

    // Asynchronous reset while in R_ACK, with Ri already high at release
    hs.Ro_PLUS = 1'b1;
    tick();
    hs.Ro_PLUS = 1'b0;
    hs.Ai = 1'b1;
    repeat (D + 2) tick();
    chk("ack_Ro", hs.Ro, 1);
    #2;
    reset = 1'b0;
    hs.Ai = 1'b0;
    hs.Ri = 1'b1;
    #1;
    chk("async_Ro", hs.Ro, 0);
    chk("async_cnt", hs.xfer_cnt, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (D + 1) tick();
    chk("rel_Ri_PLUS", hs.Ri_PLUS, 1);
    hs.Ro_PLUS = 1'b1;
    tick();
    hs.Ro_PLUS = 1'b0;
    chk("idle_Ro", hs.Ro, 1);
    chk("idle_err", hs.err, 0);

    // Randomised traffic, biased toward legal progress
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clr_cmds();
      if ($urandom_range(15) == 0) hs.Ri = ~hs.Ri;
      if ($urandom_range(15) == 0) hs.Ai = ~hs.Ai;
      hs.Ro_PLUS  = ($urandom_range(23) == 0);
      hs.Ro_MINUS = ($urandom_range(23) == 0);
      hs.Ao_PLUS  = ($urandom_range(23) == 0);
      hs.Ao_MINUS = ($urandom_range(23) == 0);
      if ($urandom_range(2) == 0) begin
        case (rp)
          0: hs.Ro_PLUS = 1'b1;
          2: hs.Ro_MINUS = 1'b1;
          default: ;
        endcase
        case (lp)
          1: hs.Ao_PLUS = 1'b1;
          3: hs.Ao_MINUS = 1'b1;
          default: ;
        endcase
      end
      if ($urandom_range(3) == 0) begin
        if (rp == 1) hs.Ai = 1'b1;
        if (rp == 3) hs.Ai = 1'b0;
        if (lp == 0) hs.Ri = 1'b1;
        if (lp == 2) hs.Ri = 1'b0;
      end
      hs.err_clr = ($urandom_range(19) == 0);
      if ($urandom_range(499) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msfsm_hs_adapter.md
MSFSM_HS_ADAPTER -- requirements
Module: msfsm_hs_adapter

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-handshake counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Ri  in  1  level request from the left sender.
REQ-005 Ai  in  1  level acknowledge from the right receiver.
REQ-006 Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS  in  1 each  one-cycle event commands from the MSFSM controller.
REQ-007 err_clr  in  1  synchronous clear of the error flags.
REQ-008 Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS  out  1 each  registered one-cycle event pulses to the controller.
REQ-009 Ro, Ao  out  1 each  registered level outputs to the channels.
REQ-010 err  out  3  sticky flags: [0] left-channel violation, [1] right-channel violation, [2] conflicting PLUS/MINUS command in one cycle.
REQ-011 xfer_cnt  out  CNT_W  count of completed right-channel 4-phase cycles.

Function
REQ-012 Input sampling SHALL give Ri_s/Ai_s = Ri/Ai registered once; Ri_p/Ai_p SHALL hold the previous Ri_s/Ai_s.
REQ-013 At each edge: Ri_PLUS <= Ri_s & ~Ri_p; Ri_MINUS <= ~Ri_s & Ri_p; Ai likewise. Each pulse SHALL be exactly one cycle per level change.
REQ-014 Latency (macro off): Ri/Ai change before edge k -> pulse high in the cycle after edge k+1.
REQ-015 Ro SHALL set on an accepted Ro_PLUS and clear on an accepted Ro_MINUS. Ao SHALL behave the same with Ao_PLUS/Ao_MINUS. The level changes at the next edge.
REQ-016 Left FSM (Ri,Ao) SHALL cycle L_IDLE -Ri_PLUS-> L_REQ -Ao_PLUS-> L_ACK -Ri_MINUS-> L_REL -Ao_MINUS-> L_IDLE.
REQ-017 Right FSM (Ro,Ai) SHALL cycle R_IDLE -Ro_PLUS-> R_REQ -Ai_PLUS-> R_ACK -Ro_MINUS-> R_REL -Ai_MINUS-> R_IDLE.
REQ-018 A channel event that is not the single legal event for the current state SHALL set that channel's err bit and leave the FSM state unchanged.
REQ-019 An illegal Ao_*/Ro_* command SHALL NOT change Ao/Ro.
REQ-020 Two events on one channel in the same cycle SHALL be illegal; the legal one, if any, is also rejected.
REQ-021 Simultaneous PLUS and MINUS of one command SHALL set err[2] plus the channel bit; Ro/Ao hold.
REQ-022 xfer_cnt SHALL increment on the accepted R_REL->R_IDLE transition and wrap from all-ones to 0.
REQ-023 err bits SHALL be sticky until err_clr. err_clr together with a new violation leaves the bit set (set wins).
REQ-024 The FSMs SHALL continue after an error; only accepted events advance state.

Reset
REQ-025 Reset asserted (low) SHALL immediately force all pulses, Ro, Ao, err and xfer_cnt to 0, both FSMs to IDLE, and all sample registers to 0.
REQ-026 Reset mid-handshake SHALL abandon the handshake without counting it.
REQ-027 A Ri/Ai level already high at reset release SHALL produce a PLUS pulse per REQ-013.

Configuration
REQ-028 Macro MSFSM_HS_SYNC_IN_EN defined: Ri/Ai SHALL pass through a 2-flop synchroniser before REQ-012 sampling, adding 2 cycles of latency.
REQ-029 Macro undefined: single-register sampling only, latency per REQ-014.

Verification
REQ-030 Reset, then Ri 0->1 held -> Ri_PLUS high exactly 1 cycle, 2 edges later (4 with macro); left FSM in L_REQ.
REQ-031 Full right cycle Ro_PLUS, Ai 1, Ro_MINUS, Ai 0, repeated 3 times -> Ro toggles 1/0 each cycle; xfer_cnt=3; err=0.
REQ-032 Ro_PLUS issued while in R_REQ -> err=3'b010; Ro stays 1; state stays R_REQ; err_clr -> err=0.
REQ-033 Ao_PLUS and Ao_MINUS asserted in the same cycle -> err=3'b101; Ao unchanged.
REQ-034 CNT_W=4 with 16 completed cycles -> xfer_cnt wraps to 0.
REQ-035 Reset asserted in R_ACK -> Ro=0, xfer_cnt=0, right FSM in R_IDLE within the reset cycle, asynchronously.
